// File: rtl/add_sched.sv
`default_nettype none
// ============================================================================
//  Module   : add_sched (with helper addn)
//  Brief    : Round-robin scheduler sharing one N-bit word-serial adder among
//             REQ requesters. Each request adds two WORDS*N-bit operands LSW
//             first with a chained carry. One transaction is in flight at a time.
//  Optional : define ADD_SCHED_OVF_EN to add the rsp_ovf output, which reports
//             signed two's-complement overflow of the W-bit sum.
//  Revision : 1.0 - initial release
// ============================================================================

module addn #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] s,
    output logic         co
);
    assign {co, s} = {1'b0, a} + {1'b0, b};
endmodule

module add_sched #(
    parameter  int N     = 8,
    parameter  int WORDS = 4,
    parameter  int REQ   = 2,
    localparam int W     = WORDS * N,
    localparam int IDW   = (REQ > 1) ? $clog2(REQ) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REQ-1:0]   req_valid,
    output logic [REQ-1:0]   req_ready,
    input  logic [REQ*W-1:0] req_a,
    input  logic [REQ*W-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [IDW-1:0]   rsp_id,
    output logic [W-1:0]     rsp_sum,
    output logic             rsp_carry
`ifdef ADD_SCHED_OVF_EN
    ,
    output logic             rsp_ovf
`endif
);

    localparam int             CW     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0]  C_LAST = CW'(WORDS - 1);
    localparam logic [IDW-1:0] C_PTR0 = IDW'(REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [CW-1:0]  r_cnt;
    logic           r_carry;
    logic [IDW-1:0] r_ptr;

    logic           w_found;
    logic [IDW-1:0] w_win;
    logic [IDW-1:0] w_idx;
    logic [REQ-1:0] w_grant;
    logic           w_accept;
    logic [W-1:0]   w_sel_a;
    logic [W-1:0]   w_sel_b;

    logic [N-1:0]   w_a_word;
    logic [N-1:0]   w_b_word;
    logic [N-1:0]   w_cin;
    logic [N-1:0]   w_s1;
    logic [N-1:0]   w_s2;
    logic           w_c1;
    logic           w_c2;
    logic           w_cout;
    logic           w_last;

    // Round-robin search: first valid requester starting just after the pointer
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 1; i <= REQ; i++) begin
            w_idx = IDW'((int'(r_ptr) + i) % REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // Operand mux for the current winner
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int r = 0; r < REQ; r++) begin
            if (w_win == IDW'(r)) begin
                w_sel_a = req_a[r*W +: W];
                w_sel_b = req_b[r*W +: W];
            end
        end
    end

    // One-hot grant only while idle and out of reset
    always_comb begin
        w_grant = '0;
        if (w_found && (r_state == S_IDLE)) begin
            w_grant[w_win] = 1'b1;
        end
        req_ready = rst_n ? w_grant : '0;
    end

    assign w_accept = (r_state == S_IDLE) && w_found;
    assign w_last   = (r_cnt == C_LAST);

    // Shared word datapath: s1 = a + b, s2 = s1 + carry-in
    assign w_a_word = r_a[r_cnt*N +: N];
    assign w_b_word = r_b[r_cnt*N +: N];
    assign w_cin    = N'(r_carry);
    assign w_cout   = w_c1 | w_c2;

    addn #(.N(N)) u_add_ab (
        .a  (w_a_word),
        .b  (w_b_word),
        .s  (w_s1),
        .co (w_c1)
    );

    addn #(.N(N)) u_add_cin (
        .a  (w_s1),
        .b  (w_cin),
        .s  (w_s2),
        .co (w_c2)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)  w_state_nxt = S_RUN;
            S_RUN:   if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  if (rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, word-serial accumulation and response handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_cnt     <= '0;
            r_carry   <= 1'b0;
            r_ptr     <= C_PTR0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
`ifdef ADD_SCHED_OVF_EN
            rsp_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= w_sel_a;
                        r_b     <= w_sel_b;
                        rsp_id  <= w_win;
                        r_cnt   <= '0;
                        r_carry <= 1'b0;
                    end
                end
                S_RUN: begin
                    rsp_sum[r_cnt*N +: N] <= w_s2;
                    r_carry               <= w_cout;
                    r_cnt                 <= r_cnt + 1'b1;
                    if (w_last) begin
                        rsp_valid <= 1'b1;
                        rsp_carry <= w_cout;
`ifdef ADD_SCHED_OVF_EN
                        // Word WORDS-1 carries the sign bit of the full sum
                        rsp_ovf   <= (r_a[W-1] == r_b[W-1]) && (w_s2[N-1] != r_a[W-1]);
`endif
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_ptr     <= rsp_id;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_add_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_add_sched
//  Brief    : Directed self-checking bench for add_sched (N=8, WORDS=4, REQ=2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_add_sched;

    localparam int N     = 8;
    localparam int WORDS = 4;
    localparam int REQ   = 2;
    localparam int W     = N * WORDS;

    logic             clk;
    logic             rst_n;
    logic [REQ-1:0]   req_valid;
    logic [REQ-1:0]   req_ready;
    logic [REQ*W-1:0] req_a;
    logic [REQ*W-1:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [0:0]       rsp_id;
    logic [W-1:0]     rsp_sum;
    logic             rsp_carry;
`ifdef ADD_SCHED_OVF_EN
    logic             rsp_ovf;
`endif

    int n_checks = 0;
    int n_errors = 0;

    add_sched #(.N(N), .WORDS(WORDS), .REQ(REQ)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry)
`ifdef ADD_SCHED_OVF_EN
        ,
        .rsp_ovf   (rsp_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

`ifdef ADD_SCHED_OVF_EN
    task automatic run_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic exp_ovf, input logic exp_carry);
        int t;
        req_a[W-1:0] = a;
        req_b[W-1:0] = b;
        req_valid    = 2'b01;
        t = 0;
        #1;
        while (req_ready == '0 && t < 20) begin
            @(negedge clk); #1; t++;
        end
        check("ovf_grant", req_ready, 2'b01);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        t = 0;
        while (!rsp_valid && t < 20) begin
            @(negedge clk); t++;
        end
        check("ovf_valid", rsp_valid, 1'b1);
        check("ovf_flag", {rsp_ovf, rsp_carry}, {exp_ovf, exp_carry});
        @(negedge clk);
    endtask
`endif

    int g_cyc [8];
    logic [1:0] g_val [8];
    int ng, nr, first_g, first_r;
    logic [1:0] first_gv;
    logic [33:0] first_rv;

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        req_valid = 2'b11;
        req_a     = {32'h1234_5678, 32'hFFFF_FFFF};
        req_b     = {32'h1111_1111, 32'h0000_0001};

        // Reset state with requests pending
        repeat (3) @(negedge clk);
        check("reset_ctl", {rsp_valid, req_ready, rsp_id, rsp_carry}, '0);
        check("reset_sum", rsp_sum, '0);

        // Both valid: requester 0 wins first
        rst_n = 1'b1;
        #1;
        check("first_grant", req_ready, 2'b01);
        @(posedge clk);

        // Latency: rsp_valid after exactly 4 edges past acceptance
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (k == 0) begin
                req_a[W-1:0] = 32'hDEAD_BEEF;
                req_b[W-1:0] = 32'h0101_0101;
            end
            check("latency_valid", rsp_valid, (k == 4));
            check("run_ready", req_ready, 2'b00);
        end
        check("wrap_result", {rsp_id, rsp_carry, rsp_sum}, {1'b0, 1'b1, 32'h0000_0000});

        // Consumer stall: response held, no grants
        req_a[W-1:0] = 32'h8000_0001;
        req_b[W-1:0] = 32'h8000_00FF;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("stall_hold", {rsp_valid, req_ready, rsp_id, rsp_carry, rsp_sum},
                  {1'b1, 2'b00, 1'b0, 1'b1, 32'h0000_0000});
        end

        // Continuous traffic from both: grants alternate, 6-cycle spacing
        rsp_ready = 1'b1;
        ng = 0;
        nr = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check("kept_after_hs", {rsp_valid, rsp_carry, rsp_sum}, {1'b0, 1'b1, 32'h0});
            end
            if (req_ready != 2'b00 && ng < 8) begin
                g_cyc[ng] = c;
                g_val[ng] = req_ready;
                ng++;
            end
            if (rsp_valid) begin
                check("alt_rsp_cycle", c, 5 + 6 * nr);
                if (nr % 2 == 0)
                    check("alt_rsp_r1", {rsp_id, rsp_carry, rsp_sum}, {1'b1, 1'b0, 32'h2345_6789});
                else
                    check("alt_rsp_r0", {rsp_id, rsp_carry, rsp_sum}, {1'b0, 1'b1, 32'h0000_0100});
                nr++;
            end
        end
        check("alt_grant_count", ng, 4);
        check("alt_rsp_count", nr, 4);
        for (int i = 0; i < 4; i++) begin
            check("alt_grant_cycle", g_cyc[i], 6 * i);
            check("alt_grant_id", g_val[i], (i % 2 == 0) ? 2'b10 : 2'b01);
        end

        // Reset two cycles into RUN discards the transaction
        req_valid = 2'b00;
        @(negedge clk);
        check("idle_after_hs", rsp_valid, 1'b0);
        req_valid = 2'b01;
        #1;
        check("rst_test_grant", req_ready, 2'b01);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_ctl", {rsp_valid, req_ready, rsp_id, rsp_carry}, '0);
        check("async_rst_sum", rsp_sum, '0);
        repeat (2) begin
            @(negedge clk);
            check("in_reset_valid", rsp_valid, 1'b0);
        end

        // Requester 1 alone after release
        req_valid = 2'b10;
        rst_n     = 1'b1;
        first_g   = -1;
        first_r   = -1;
        first_gv  = '0;
        first_rv  = '0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (req_ready != 2'b00 && first_g < 0) begin
                first_g  = c;
                first_gv = req_ready;
            end
            if (rsp_valid && first_r < 0) begin
                first_r  = c;
                first_rv = {rsp_id, rsp_carry, rsp_sum};
            end
            @(negedge clk);
            if (c == 0) req_valid = 2'b00;
        end
        check("post_rst_grant_cycle", first_g, 0);
        check("post_rst_grant", first_gv, 2'b10);
        check("post_rst_rsp_cycle", first_r, 5);
        check("post_rst_rsp", first_rv, {1'b1, 1'b0, 32'h2345_6789});

`ifdef ADD_SCHED_OVF_EN
        run_ovf(32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b0);
        run_ovf(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
